// File: rtl/jelly_wishbone_line_pkg.sv
// Shared types and width helpers for the line-to-word Wishbone responder.
// Used by jelly_wishbone_line_responder and jelly_line_word_slice.
package jelly_wishbone_line_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } line_state_e;

  function automatic int calc_line_words(input int line_size);
    return 1 << line_size;
  endfunction

  function automatic int calc_slice_width(input int word_size);
    return 8 << word_size;
  endfunction

  // A line of one word still needs a 1-bit index so vectors stay legal.
  function automatic int calc_idx_width(input int line_size);
    return (line_size > 0) ? line_size : 1;
  endfunction

endpackage

// File: rtl/jelly_line_word_slice.sv
// Endian-aware access to word idx_i of a line: word_o extracts it and
// line_o is line_i with that slot replaced by word_i.
module jelly_line_word_slice
  import jelly_wishbone_line_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int SLICE_W    = 32,
  parameter int IDX_W      = 2
) (
  input  logic [LINE_WORDS*SLICE_W-1:0] line_i,
  input  logic [IDX_W-1:0]              idx_i,
  input  logic                          endian_i,
  input  logic [SLICE_W-1:0]            word_i,
  output logic [SLICE_W-1:0]            word_o,
  output logic [LINE_WORDS*SLICE_W-1:0] line_o
);

  logic [IDX_W-1:0] pos;

  // Big endian places word 0 in the most significant slot.
  assign pos = endian_i ? (IDX_W'(LINE_WORDS - 1) - idx_i) : idx_i;

  always_comb begin
    word_o = '0;
    line_o = line_i;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (IDX_W'(i) == pos) begin
        word_o                       = line_i[i*SLICE_W +: SLICE_W];
        line_o[i*SLICE_W +: SLICE_W] = word_i;
      end
    end
  end

endmodule

// File: rtl/jelly_wishbone_line_responder.sv
// Wishbone slave that serializes one line-wide request into LINE_WORDS word
// accesses. Define JELLY_WISHBONE_LINE_RESPONDER_SKIP_SEL_EN to skip
// write words whose byte selects are all zero.
module jelly_wishbone_line_responder
  import jelly_wishbone_line_pkg::*;
#(
  parameter int LINE_SIZE   = 2,
  parameter int WORD_SIZE   = 2,
  parameter int S_ADR_WIDTH = 22,
  parameter int LINE_WORDS  = calc_line_words(LINE_SIZE),
  parameter int M_ADR_WIDTH = S_ADR_WIDTH + LINE_SIZE,
  parameter int M_DAT_WIDTH = calc_slice_width(WORD_SIZE),
  parameter int M_SEL_WIDTH = 1 << WORD_SIZE,
  parameter int S_DAT_WIDTH = M_DAT_WIDTH * LINE_WORDS,
  parameter int S_SEL_WIDTH = M_SEL_WIDTH * LINE_WORDS
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic                   endian,

  input  logic [S_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [S_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [S_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic                   s_wb_we_i,
  input  logic [S_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                   s_wb_stb_i,
  output logic                   s_wb_ack_o,

  output logic [M_ADR_WIDTH-1:0] m_wb_adr_o,
  input  logic [M_DAT_WIDTH-1:0] m_wb_dat_i,
  output logic [M_DAT_WIDTH-1:0] m_wb_dat_o,
  output logic                   m_wb_we_o,
  output logic [M_SEL_WIDTH-1:0] m_wb_sel_o,
  output logic                   m_wb_stb_o,
  input  logic                   m_wb_ack_i
);

  localparam int IDX_W = calc_idx_width(LINE_SIZE);

  // Handshake: a downstream word completes on a rising edge where
  // m_wb_stb_o and m_wb_ack_i are both high; the upstream request is taken
  // when s_wb_stb_i is high in IDLE and retired by a one-cycle s_wb_ack_o.

  line_state_e            state_q;
  logic [IDX_W-1:0]       cnt_q;
  logic [S_ADR_WIDTH-1:0] adr_q;
  logic                   we_q;
  logic                   endian_q;
  logic [S_DAT_WIDTH-1:0] dat_q;
  logic [S_SEL_WIDTH-1:0] sel_q;
  logic [S_DAT_WIDTH-1:0] buf_q;

  logic                   s_ack_q;
  logic [S_DAT_WIDTH-1:0] s_dat_q;
  logic                   m_stb_q;
  logic                   m_we_q;
  logic [M_ADR_WIDTH-1:0] m_adr_q;
  logic [M_DAT_WIDTH-1:0] m_dat_q;
  logic [M_SEL_WIDTH-1:0] m_sel_q;

  assign s_wb_ack_o = s_ack_q;
  assign s_wb_dat_o = s_dat_q;
  assign m_wb_stb_o = m_stb_q;
  assign m_wb_we_o  = m_we_q;
  assign m_wb_adr_o = m_adr_q;
  assign m_wb_dat_o = m_dat_q;
  assign m_wb_sel_o = m_sel_q;

  // While idle the next word comes straight from the request being accepted.
  logic                   idle;
  logic [IDX_W-1:0]       nxt_cnt;
  logic [S_ADR_WIDTH-1:0] src_adr;
  logic                   src_we;
  logic                   src_endian;
  logic [S_DAT_WIDTH-1:0] src_dat;
  logic [S_SEL_WIDTH-1:0] src_sel;

  assign idle       = (state_q == IDLE);
  assign nxt_cnt    = idle ? '0 : (cnt_q + IDX_W'(1));
  assign src_adr    = idle ? s_wb_adr_i : adr_q;
  assign src_we     = idle ? s_wb_we_i  : we_q;
  assign src_endian = idle ? endian     : endian_q;
  assign src_dat    = idle ? s_wb_dat_i : dat_q;
  assign src_sel    = idle ? s_wb_sel_i : sel_q;

  logic [M_DAT_WIDTH-1:0] nxt_dat;
  logic [M_SEL_WIDTH-1:0] nxt_sel;
  logic [S_DAT_WIDTH-1:0] buf_line_d;
  logic [S_DAT_WIDTH-1:0] dat_line_unused;
  logic [S_SEL_WIDTH-1:0] sel_line_unused;
  logic [M_DAT_WIDTH-1:0] buf_word_unused;

  jelly_line_word_slice #(
    .LINE_WORDS (LINE_WORDS),
    .SLICE_W    (M_DAT_WIDTH),
    .IDX_W      (IDX_W)
  ) u_dat_slice (
    .line_i   (src_dat),
    .idx_i    (nxt_cnt),
    .endian_i (src_endian),
    .word_i   ('0),
    .word_o   (nxt_dat),
    .line_o   (dat_line_unused)
  );

  jelly_line_word_slice #(
    .LINE_WORDS (LINE_WORDS),
    .SLICE_W    (M_SEL_WIDTH),
    .IDX_W      (IDX_W)
  ) u_sel_slice (
    .line_i   (src_sel),
    .idx_i    (nxt_cnt),
    .endian_i (src_endian),
    .word_i   ('0),
    .word_o   (nxt_sel),
    .line_o   (sel_line_unused)
  );

  jelly_line_word_slice #(
    .LINE_WORDS (LINE_WORDS),
    .SLICE_W    (M_DAT_WIDTH),
    .IDX_W      (IDX_W)
  ) u_buf_slice (
    .line_i   (buf_q),
    .idx_i    (cnt_q),
    .endian_i (endian_q),
    .word_i   (m_wb_dat_i),
    .word_o   (buf_word_unused),
    .line_o   (buf_line_d)
  );

  logic nxt_skip;
`ifdef JELLY_WISHBONE_LINE_RESPONDER_SKIP_SEL_EN
  assign nxt_skip = src_we && (nxt_sel == '0);
`else
  assign nxt_skip = 1'b0;
`endif

  logic [M_ADR_WIDTH-1:0] nxt_adr;
  logic                   step;
  logic                   last;

  assign nxt_adr = (M_ADR_WIDTH'(src_adr) << LINE_SIZE) | M_ADR_WIDTH'(nxt_cnt);
  // A skipped word (strobe low) advances unconditionally after one cycle.
  assign step    = m_stb_q ? m_wb_ack_i : 1'b1;
  assign last    = (cnt_q == IDX_W'(LINE_WORDS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      adr_q    <= '0;
      we_q     <= 1'b0;
      endian_q <= 1'b0;
      dat_q    <= '0;
      sel_q    <= '0;
      buf_q    <= '0;
      s_ack_q  <= 1'b0;
      s_dat_q  <= '0;
      m_stb_q  <= 1'b0;
      m_we_q   <= 1'b0;
      m_adr_q  <= '0;
      m_dat_q  <= '0;
      m_sel_q  <= '0;
    end else begin
      s_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_wb_stb_i) begin
            adr_q    <= s_wb_adr_i;
            we_q     <= s_wb_we_i;
            endian_q <= endian;
            dat_q    <= s_wb_dat_i;
            sel_q    <= s_wb_sel_i;
            cnt_q    <= '0;
            m_stb_q  <= !nxt_skip;
            m_we_q   <= src_we;
            m_adr_q  <= nxt_adr;
            m_dat_q  <= nxt_dat;
            m_sel_q  <= nxt_sel;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          if (step) begin
            if (m_stb_q && !we_q) begin
              buf_q <= buf_line_d;
            end
            if (last) begin
              m_stb_q <= 1'b0;
              state_q <= ACK;
            end else begin
              cnt_q   <= nxt_cnt;
              m_stb_q <= !nxt_skip;
              m_adr_q <= nxt_adr;
              m_dat_q <= nxt_dat;
              m_sel_q <= nxt_sel;
            end
          end
        end
        ACK: begin
          s_ack_q <= 1'b1;
          if (!we_q) begin
            s_dat_q <= buf_q;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
